// File: rtl/tile_spawn_pkg.sv
// Shared types and constants for the tile spawn controller.
package tile_spawn_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } spawn_state_e;

   localparam int NUM_CELLS = 16;
   localparam int CELL_W    = 4;

   localparam logic [1:0] EXP_NONE = 2'd0;
   localparam logic [1:0] EXP_TWO  = 2'd1;
   localparam logic [1:0] EXP_FOUR = 2'd2;

endpackage

// File: rtl/tile_spawn_ctrl.sv
// Picks an empty cell (random start, wrap-around scan) and a tile value for each spawn request.
// Optional feature macro SPAWN_FOUR_EN: enables the weighted 2/4 tile choice via FOUR_WEIGHT.
module tile_spawn_ctrl
   import tile_spawn_pkg::*;
#(
   parameter int FOUR_WEIGHT = 2
) (
   input  logic              CLOCK_50,
   input  logic              resetn,
   input  logic [CELL_W-1:0] rand_value,
   input  logic [NUM_CELLS-1:0] occupancy,
   input  logic              spawn_req,
   output logic              busy,
   output logic              spawn_ack,
   output logic [CELL_W-1:0] spawn_cell,
   output logic [1:0]        spawn_exp,
   output logic              no_space
);

   if (FOUR_WEIGHT < 0 || FOUR_WEIGHT > NUM_CELLS) begin : g_bad_weight
      $error("FOUR_WEIGHT must lie in 0..16");
   end

   spawn_state_e         state_q, state_d;
   logic [CELL_W-1:0]    idx_q, idx_d;
   logic [CELL_W-1:0]    cnt_q, cnt_d;
   logic [NUM_CELLS-1:0] occ_q, occ_d;
   logic [CELL_W-1:0]    cell_d;
   logic [1:0]           exp_d;
   logic                 no_space_d;
   logic [1:0]           found_exp;

`ifdef SPAWN_FOUR_EN
   // Second counter sample, taken in the cycle the empty cell is found.
   assign found_exp = ({1'b0, rand_value} < 5'(FOUR_WEIGHT)) ? EXP_FOUR : EXP_TWO;
`else
   assign found_exp = EXP_TWO;
`endif

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves a value unassigned (no latches).
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      occ_d      = occ_q;
      cell_d     = spawn_cell;
      exp_d      = spawn_exp;
      no_space_d = no_space;

      unique case (state_q)
         IDLE: begin
            if (spawn_req) begin
               occ_d   = occupancy;
               idx_d   = rand_value;
               cnt_d   = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (!occ_q[idx_q]) begin
               cell_d     = idx_q;
               exp_d      = found_exp;
               no_space_d = 1'b0;
               state_d    = DONE;
            end else if (cnt_q == CELL_W'(NUM_CELLS - 1)) begin
               cell_d     = idx_q;
               exp_d      = EXP_NONE;
               no_space_d = 1'b1;
               state_d    = DONE;
            end else begin
               idx_d = idx_q + 1'b1;  // 4-bit wrap from cell 15 back to cell 0
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         occ_q      <= '0;
         spawn_cell <= '0;
         spawn_exp  <= EXP_NONE;
         no_space   <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         occ_q      <= occ_d;
         spawn_cell <= cell_d;
         spawn_exp  <= exp_d;
         no_space   <= no_space_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign spawn_ack = (state_q == DONE);

endmodule

// File: tb/tb_tile_spawn_ctrl.sv
// Directed self-checking bench for tile_spawn_ctrl (follows SPAWN_FOUR_EN if defined).
module tb_tile_spawn_ctrl;

   logic       CLOCK_50 = 1'b0;
   logic       resetn;
   logic [3:0] rand_value;
   logic [15:0] occupancy;
   logic       spawn_req;
   logic       busy;
   logic       spawn_ack;
   logic [3:0] spawn_cell;
   logic [1:0] spawn_exp;
   logic       no_space;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef SPAWN_FOUR_EN
   localparam int EXP_LOW_RAND = 2;  // rand_value 1 < FOUR_WEIGHT gives a 4-tile
`else
   localparam int EXP_LOW_RAND = 1;
`endif

   tile_spawn_ctrl #(.FOUR_WEIGHT(2)) dut (
      .CLOCK_50   (CLOCK_50),
      .resetn     (resetn),
      .rand_value (rand_value),
      .occupancy  (occupancy),
      .spawn_req  (spawn_req),
      .busy       (busy),
      .spawn_ack  (spawn_ack),
      .spawn_cell (spawn_cell),
      .spawn_exp  (spawn_exp),
      .no_space   (no_space)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   // Issues a one-cycle request, then waits (bounded) for the ack and checks its latency and result.
   task automatic run_spawn(input string tag, input logic [15:0] occ, input logic [3:0] r_start,
                            input logic [3:0] r_find, input int exp_lat, input int exp_cell,
                            input int exp_exp, input int exp_ns);
      int lat;
      spawn_req  = 1'b1;
      occupancy  = occ;
      rand_value = r_start;
      step();
      spawn_req  = 1'b0;
      occupancy  = ~occ;
      rand_value = r_find;
      lat = 1;
      while (!spawn_ack && lat < 25) begin
         check({tag, "_busy"}, busy, 1);
         step();
         lat++;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_busy_done"}, busy, 1);
      check({tag, "_cell"}, spawn_cell, exp_cell);
      check({tag, "_exp"}, spawn_exp, exp_exp);
      check({tag, "_no_space"}, no_space, exp_ns);
      step();
      check({tag, "_idle_busy"}, busy, 0);
      check({tag, "_idle_ack"}, spawn_ack, 0);
      check({tag, "_hold_cell"}, spawn_cell, exp_cell);
   endtask

   initial begin
      int acks;
      resetn     = 1'b0;
      spawn_req  = 1'b0;
      occupancy  = '0;
      rand_value = '0;
      #12;
      check("rst_busy", busy, 0);
      check("rst_ack", spawn_ack, 0);
      check("rst_cell", spawn_cell, 0);
      check("rst_exp", spawn_exp, 0);
      check("rst_no_space", no_space, 0);
      resetn = 1'b1;
      step();

      run_spawn("empty_board", 16'h0000, 4'd5, 4'd9, 2, 5, 1, 0);
      run_spawn("wrap", 16'hC000, 4'd14, 4'd9, 4, 0, 1, 0);
      run_spawn("full", 16'hFFFF, 4'd3, 4'd1, 17, 2, 0, 1);
      run_spawn("weight_low", 16'h0000, 4'd7, 4'd1, 2, 7, EXP_LOW_RAND, 0);
      run_spawn("weight_edge", 16'h0000, 4'd7, 4'd2, 2, 7, 1, 0);
      run_spawn("skip_one", 16'h0010, 4'd4, 4'd0, 3, 5, EXP_LOW_RAND, 0);

      // Held request: acks after edges 2, 5, 8, 11 counted from the first accept.
      spawn_req = 1'b1;
      occupancy = '0;
      rand_value = 4'd9;
      for (int i = 1; i <= 12; i++) begin
         step();
         check($sformatf("held_ack_%0d", i), spawn_ack, (i % 3 == 2) ? 1 : 0);
      end
      spawn_req = 1'b0;
      step();
      step();

      // Pulse during SCAN must be ignored: exactly one ack for the scan of cells 0..8.
      spawn_req  = 1'b1;
      occupancy  = 16'h00FF;
      rand_value = 4'd0;
      step();
      spawn_req = 1'b0;
      acks = 0;
      for (int i = 2; i <= 14; i++) begin
         spawn_req = (i == 4);
         step();
         if (spawn_ack) acks++;
      end
      spawn_req = 1'b0;
      check("pulse_acks", acks, 1);
      check("pulse_cell", spawn_cell, 8);
      check("pulse_idle", busy, 0);

      // Reset mid-scan aborts with no ack.
      spawn_req  = 1'b1;
      occupancy  = 16'h7FFF;
      rand_value = 4'd0;
      step();
      spawn_req = 1'b0;
      for (int i = 0; i < 5; i++) step();
      check("pre_rst_busy", busy, 1);
      resetn = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ack", spawn_ack, 0);
      check("mid_rst_cell", spawn_cell, 0);
      check("mid_rst_exp", spawn_exp, 0);
      check("mid_rst_no_space", no_space, 0);
      step();
      resetn = 1'b1;
      acks = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (spawn_ack || busy) acks++;
      end
      check("post_rst_quiet", acks, 0);
      run_spawn("after_reset", 16'h0000, 4'd6, 4'd9, 2, 6, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tile_spawn_ctrl.md
# tile_spawn_ctrl

Controller that sequences the free-running 4-bit random counter to place a new tile on the 4x4 board after each move. On request it samples the counter for a start cell and scans the board occupancy mask with wrap-around until it finds an empty cell. It then samples the counter again to choose a 2 or a 4 tile. It sits between the move/merge logic (requester) and the board register file (consumer of the spawn result).

## Interface
- FOUR_WEIGHT, default 2: a 4-tile is chosen when the second counter sample is < FOUR_WEIGHT (range 0..16; 2 gives a 2/16 chance).
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- rand_value  in  4  current value of the free-running counter.
- occupancy  in  16  board mask; bit i = 1 means cell i is occupied (cell index = row*4+col).
- spawn_req  in  1  level request; accepted only in IDLE.
- busy  out  1  high from the cycle after acceptance through the DONE cycle.
- spawn_ack  out  1  one-cycle pulse; result outputs are valid in this cycle.
- spawn_cell  out  4  chosen cell index.
- spawn_exp  out  2  log2 of the tile value: 1 = tile 2, 2 = tile 4; 0 when no_space.
- no_space  out  1  board full; no tile placed.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - If spawn_req = 1: latch occupancy into occ_q, set idx <= rand_value and cnt <= 0, go to SCAN.
  - Otherwise stay in IDLE.
- SCAN, one cell checked per cycle:
  - occ_q[idx] = 0: spawn_cell <= idx; spawn_exp <= (rand_value < FOUR_WEIGHT) ? 2 : 1; no_space <= 0; go to DONE.
  - Else if cnt = 15: no_space <= 1; spawn_exp <= 0; spawn_cell <= idx; go to DONE.
  - Else: idx <= idx + 1 (4-bit, wraps 15 -> 0); cnt <= cnt + 1.
- DONE: spawn_ack = 1 for exactly this cycle, then go to IDLE unconditionally.
- spawn_cell, spawn_exp and no_space hold their last result until the next DONE.
- occupancy changes after acceptance are ignored; the scan uses only occ_q.
- spawn_req while busy is ignored and not queued.
- A request held high through DONE is accepted again in the following IDLE cycle.
- Reset mid-scan aborts the scan: no ack is issued and the controller returns to IDLE.

## Timing
- Reset values:
  - state = IDLE; busy, spawn_ack and no_space = 0; spawn_cell = 0; spawn_exp = 0.
  - idx, cnt and occ_q = 0.
- Request accepted at edge N; first cell checked in cycle N+1.
- spawn_ack is high in cycle N+2+k, where k = number of occupied cells skipped (k = 0..15).
- Board full: ack in cycle N+17 with no_space = 1.
- Minimum request-to-request spacing is 3 cycles (accept, SCAN, DONE).
- The 4-tile decision uses rand_value in the same cycle the empty cell is found, not the start-cell sample.

## Configuration
- SPAWN_FOUR_EN defined: tile value is chosen with FOUR_WEIGHT as above.
- SPAWN_FOUR_EN undefined: spawn_exp is always 1 on success (always a 2-tile); FOUR_WEIGHT is unused; no second counter sample is taken.

## Structure
- Package tile_spawn_pkg holds:
  - state enum (IDLE, SCAN, DONE);
  - NUM_CELLS = 16, CELL_W = 4;
  - EXP_NONE = 0, EXP_TWO = 1, EXP_FOUR = 2.
- No sub-module: the FSM, index counter and mask are a single flat module.

## Test plan
- occupancy=16'h0000, rand_value=4'd5 at accept, rand_value=4'd9 on the check cycle -> ack at N+2, spawn_cell=5, spawn_exp=1, no_space=0.
- occupancy=16'hC000, rand_value=4'd14 at accept -> cells 14 and 15 skipped, wrap to 0; ack at N+4 with spawn_cell=0.
- occupancy=16'hFFFF -> ack at N+17, no_space=1, spawn_exp=0; busy high for cycles N+1..N+17.
- With SPAWN_FOUR_EN and FOUR_WEIGHT=2: rand_value=1 on the find cycle -> spawn_exp=2; rand_value=2 -> spawn_exp=1. Without the macro: spawn_exp=1 in both cases.
- spawn_req held high continuously with occupancy=0 -> acks every 3 cycles; spawn_req pulsed during SCAN -> ignored, only one ack.
- resetn asserted mid-scan with occupancy=16'h7FFF -> outputs go to reset values immediately, no ack; the next request behaves normally.
